// File: rtl/seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_display_ctrl
//
// Multi-digit seven-segment display controller. A value is loaded through a
// valid/ready handshake and shown as hex or, when built with the optional
// converter, as decimal. Leading zeros can be blanked. A value that does not
// fit in NUM_DIGITS digits is shown as dashes, with overflow raised.
//
// Optional feature macro: SEG7_DECIMAL_EN
//   defined   : decimal mode via a sequential double-dabble engine (CONVERT).
//   undefined : load_mode is ignored; every load is hex, latency 2 cycles.
//
// Parameters:
//   NUM_DIGITS     number of digits driven (1..8)
//   DATA_W         width of load_data (1..32)
//   ACTIVE_LOW_SEG 1 = segment lit when its bit is 0, 0 = lit when 1
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   load_valid     load request (requester holds it until accepted)
//   load_ready     controller can accept a load (high only in IDLE)
//   load_data      unsigned value to display
//   load_mode      0 = hex, 1 = decimal; sampled with load_data
//   blank_lz       1 = blank leading zeros; sampled with load_data
//   segments       digit i on [7i+6:7i], bit0 = a .. bit6 = g, digit 0 = LSD
//   overflow       last displayed value did not fit in NUM_DIGITS digits
//
// Handshake: a load transfers on every rising clock edge where load_valid and
// load_ready are both high. load_valid while load_ready is low is ignored and
// nothing is buffered. load_ready is registered, so it never depends
// combinationally on load_valid.
//
// The FSM state is held in 'state' (IDLE / CONVERT / UPDATE) for observation.
// ---------------------------------------------------------------------------
module seg7_display_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DATA_W         = 16,
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DATA_W-1:0]       load_data,
    input  logic                    load_mode,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] segments,
    output logic                    overflow
);

    localparam int HEX_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;

    // XOR mask applied at the output register; also the all-segments-off
    // pattern, since an unlit active-high code is all zeros.
    localparam logic [SEG_W-1:0] SEG_INV =
        (ACTIVE_LOW_SEG != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

`ifdef SEG7_DECIMAL_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd2
    } state_t;
`endif

    state_t            state;

    // digit_q holds the nibbles to display: the raw hex value in hex mode,
    // or the BCD accumulator in decimal mode.
    logic [HEX_W-1:0]  digit_q;
    logic              ovf_q;
    logic              blank_q;

`ifdef SEG7_DECIMAL_EN
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [HEX_W-1:0]  bcd_adj;
`else
    logic              unused_load_mode;
    assign unused_load_mode = load_mode;
`endif

    logic              hex_over;
    logic [SEG_W-1:0]  seg_next;
    logic [3:0]        nib;
    logic              seen_nonzero;

    // Active-high glyph for one hex digit.
    function automatic logic [6:0] glyph(input logic [3:0] value);
        case (value)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Hex overflow: any set input bit beyond the digits we can show.
    always_comb begin
        hex_over = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= HEX_W) begin
                hex_over = hex_over | load_data[i];
            end
        end
    end

`ifdef SEG7_DECIMAL_EN
    // Double-dabble correction step: +3 on every BCD nibble >= 5 before the
    // shift, so a nibble that reaches 10 carries into the next one.
    always_comb begin
        bcd_adj = digit_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = digit_q[4*i +: 4] + 4'd3;
            end
        end
    end
`endif

    // Glyph selection for all digits. Walk from the most significant digit
    // down, so seen_nonzero tells whether a digit is a leading zero.
    always_comb begin
        seg_next     = '0;
        nib          = 4'h0;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = digit_q[4*i +: 4];
            if (nib != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            if (ovf_q) begin
                seg_next[7*i +: 7] = GLYPH_DASH;
            end else if (blank_q && !seen_nonzero && (i != 0)) begin
                seg_next[7*i +: 7] = GLYPH_BLANK;
            end else begin
                seg_next[7*i +: 7] = glyph(nib);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            segments   <= SEG_INV;
            overflow   <= 1'b0;
            digit_q    <= '0;
            ovf_q      <= 1'b0;
            blank_q    <= 1'b0;
`ifdef SEG7_DECIMAL_EN
            data_q     <= '0;
            bit_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        blank_q    <= blank_lz;
                        load_ready <= 1'b0;
`ifdef SEG7_DECIMAL_EN
                        if (load_mode) begin
                            data_q  <= load_data;
                            digit_q <= '0;
                            ovf_q   <= 1'b0;
                            bit_cnt <= '0;
                            state   <= CONVERT;
                        end else begin
                            digit_q <= HEX_W'(load_data);
                            ovf_q   <= hex_over;
                            state   <= UPDATE;
                        end
`else
                        digit_q <= HEX_W'(load_data);
                        ovf_q   <= hex_over;
                        state   <= UPDATE;
`endif
                    end
                end

`ifdef SEG7_DECIMAL_EN
                CONVERT: begin
                    // One iteration per cycle, data MSB first. A 1 leaving
                    // the top of the BCD register means the value needs more
                    // digits than we have.
                    digit_q <= {bcd_adj[HEX_W-2:0], data_q[DATA_W-1]};
                    ovf_q   <= ovf_q | bcd_adj[HEX_W-1];
                    data_q  <= data_q << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_LAST) begin
                        state <= UPDATE;
                    end
                end
`endif

                UPDATE: begin
                    segments   <= seg_next ^ SEG_INV;
                    overflow   <= ovf_q;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_display_ctrl
//
// Directed bench for seg7_display_ctrl. Three instances share one stimulus:
//   u_lo : NUM_DIGITS=4, DATA_W=16, ACTIVE_LOW_SEG=1 (board default)
//   u_hi : NUM_DIGITS=4, DATA_W=16, ACTIVE_LOW_SEG=0
//   u_n2 : NUM_DIGITS=2, DATA_W=16, ACTIVE_LOW_SEG=0 (exercises hex overflow)
// Expected patterns are written active-high; the active-low expectation is
// their bitwise inverse. Decimal-only steps are built when SEG7_DECIMAL_EN is
// defined; otherwise decimal-mode loads are expected to behave as hex.
// ---------------------------------------------------------------------------
module tb_seg7_display_ctrl;

`ifdef SEG7_DECIMAL_EN
    localparam int DEC_LAT = 18;
    localparam int RST_AT  = 8;
`else
    localparam int DEC_LAT = 2;
    localparam int RST_AT  = 1;
`endif

    localparam logic [27:0] DASH4 = {4{7'h40}};
    localparam logic [13:0] DASH2 = {2{7'h40}};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_mode;
    logic        blank_lz;

    logic        rdy_lo, rdy_hi, rdy_n2;
    logic [27:0] seg_lo, seg_hi;
    logic [13:0] seg_n2;
    logic        ovf_lo, ovf_hi, ovf_n2;

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    seg7_display_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .ACTIVE_LOW_SEG(1)) u_lo (
        .clk_clk(clk), .reset_reset_n(reset_n),
        .load_valid(load_valid), .load_ready(rdy_lo),
        .load_data(load_data), .load_mode(load_mode), .blank_lz(blank_lz),
        .segments(seg_lo), .overflow(ovf_lo)
    );

    seg7_display_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .ACTIVE_LOW_SEG(0)) u_hi (
        .clk_clk(clk), .reset_reset_n(reset_n),
        .load_valid(load_valid), .load_ready(rdy_hi),
        .load_data(load_data), .load_mode(load_mode), .blank_lz(blank_lz),
        .segments(seg_hi), .overflow(ovf_hi)
    );

    seg7_display_ctrl #(.NUM_DIGITS(2), .DATA_W(16), .ACTIVE_LOW_SEG(0)) u_n2 (
        .clk_clk(clk), .reset_reset_n(reset_n),
        .load_valid(load_valid), .load_ready(rdy_n2),
        .load_data(load_data), .load_mode(load_mode), .blank_lz(blank_lz),
        .segments(seg_n2), .overflow(ovf_n2)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full output check of all three instances; e4/e2 are active-high codes.
    task automatic check_out(input string tag, input logic [27:0] e4, input logic o4,
                             input logic [13:0] e2, input logic o2);
        logic [27:0] e4_lo;
        e4_lo = ~e4;
        chk({tag, ".seg_lo"}, 32'(seg_lo), 32'(e4_lo));
        chk({tag, ".seg_hi"}, 32'(seg_hi), 32'(e4));
        chk({tag, ".seg_n2"}, 32'(seg_n2), 32'(e2));
        chk({tag, ".ovf_lo"}, 32'(ovf_lo), 32'(o4));
        chk({tag, ".ovf_hi"}, 32'(ovf_hi), 32'(o4));
        chk({tag, ".ovf_n2"}, 32'(ovf_n2), 32'(o2));
        chk({tag, ".rdy_lo"}, 32'(rdy_lo), 32'd1);
        chk({tag, ".rdy_hi"}, 32'(rdy_hi), 32'd1);
        chk({tag, ".rdy_n2"}, 32'(rdy_n2), 32'd1);
    endtask

    // Called just after the accepting edge (cycle T+1); returns the cycle
    // offset at which load_ready is seen high again, bounded at 40.
    task automatic wait_ready(output int n);
        n = 1;
        while (!rdy_lo && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic do_load(input string tag, input logic [15:0] d, input logic m,
                           input logic b, input int exp_lat);
        int n;
        int w;
        load_data  = d;
        load_mode  = m;
        blank_lz   = b;
        load_valid = 1'b1;
        w = 0;
        while (!rdy_lo && w < 50) begin
            tick();
            w++;
        end
        chk({tag, ".ready_in"}, 32'(rdy_lo), 32'd1);
        tick();
        // Scramble the inputs so a design that fails to capture them shows it.
        load_valid = 1'b0;
        load_data  = 16'hFFFF;
        load_mode  = ~m;
        blank_lz   = ~b;
        wait_ready(n);
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
    endtask

    // First load accepted, then a second load (value 1, same mode) is held
    // valid throughout the busy period and must be taken when ready returns.
    task automatic busy_test(input string tag, input logic [15:0] d1, input logic m,
                             input int lat,
                             input logic [27:0] e1, input logic [13:0] e1n2, input logic o1n2,
                             input logic [27:0] e2, input logic [13:0] e2n2);
        int n;
        load_data  = d1;
        load_mode  = m;
        blank_lz   = 1'b0;
        load_valid = 1'b1;
        chk({tag, ".ready_in"}, 32'(rdy_lo), 32'd1);
        tick();
        load_data = 16'h0001;
        wait_ready(n);
        chk({tag, ".latency1"}, 32'(n), 32'(lat));
        check_out({tag, ".first"}, e1, 1'b0, e1n2, o1n2);
        tick();
        load_valid = 1'b0;
        wait_ready(n);
        chk({tag, ".latency2"}, 32'(n), 32'(lat));
        check_out({tag, ".second"}, e2, 1'b0, e2n2, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        load_mode  = 1'b0;
        blank_lz   = 1'b0;
        repeat (3) tick();
        check_out("reset_held", 28'h0, 1'b0, 14'h0, 1'b0);
        reset_n = 1'b1;
        repeat (2) tick();
        check_out("reset_released", 28'h0, 1'b0, 14'h0, 1'b0);

        // Hex glyphs, no blanking.
        do_load("hex_1a3f", 16'h1A3F, 1'b0, 1'b0, 2);
        check_out("hex_1a3f", {7'h06, 7'h77, 7'h4F, 7'h71}, 1'b0, DASH2, 1'b1);

        // Leading-zero blanking.
        do_load("hex_0005_blz", 16'h0005, 1'b0, 1'b1, 2);
        check_out("hex_0005_blz", {7'h00, 7'h00, 7'h00, 7'h6D}, 1'b0, {7'h00, 7'h6D}, 1'b0);

        do_load("hex_0000_blz", 16'h0000, 1'b0, 1'b1, 2);
        check_out("hex_0000_blz", {7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0, {7'h00, 7'h3F}, 1'b0);

        // Only zeros above the top nonzero digit are blanked.
        do_load("hex_0b0c_blz", 16'h0B0C, 1'b0, 1'b1, 2);
        check_out("hex_0b0c_blz", {7'h00, 7'h7C, 7'h3F, 7'h39}, 1'b0, DASH2, 1'b1);

        do_load("hex_00f0", 16'h00F0, 1'b0, 1'b0, 2);
        check_out("hex_00f0", {7'h3F, 7'h3F, 7'h71, 7'h3F}, 1'b0, {7'h71, 7'h3F}, 1'b0);

`ifdef SEG7_DECIMAL_EN
        do_load("dec_1234", 16'd1234, 1'b1, 1'b0, DEC_LAT);
        check_out("dec_1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0, DASH2, 1'b1);

        do_load("dec_10000", 16'd10000, 1'b1, 1'b0, DEC_LAT);
        check_out("dec_10000", DASH4, 1'b1, DASH2, 1'b1);

        do_load("dec_9999", 16'd9999, 1'b1, 1'b0, DEC_LAT);
        check_out("dec_9999", {4{7'h6F}}, 1'b0, DASH2, 1'b1);

        do_load("dec_42_blz", 16'd42, 1'b1, 1'b1, DEC_LAT);
        check_out("dec_42_blz", {7'h00, 7'h00, 7'h66, 7'h5B}, 1'b0, {7'h66, 7'h5B}, 1'b0);

        busy_test("busy_dec", 16'd4321, 1'b1, DEC_LAT,
                  {7'h66, 7'h4F, 7'h5B, 7'h06}, DASH2, 1'b1,
                  {7'h3F, 7'h3F, 7'h3F, 7'h06}, {7'h3F, 7'h06});
`else
        // Without the converter, load_mode=1 is just another hex load.
        do_load("mode1_as_hex", 16'd1234, 1'b1, 1'b0, DEC_LAT);
        check_out("mode1_as_hex", {7'h3F, 7'h66, 7'h5E, 7'h5B}, 1'b0, DASH2, 1'b1);
`endif

        busy_test("busy_hex", 16'h4321, 1'b0, 2,
                  {7'h66, 7'h4F, 7'h5B, 7'h06}, DASH2, 1'b1,
                  {7'h3F, 7'h3F, 7'h3F, 7'h06}, {7'h3F, 7'h06});

        // Reset in the middle of a (decimal-mode) load.
        load_data  = 16'd5678;
        load_mode  = 1'b1;
        blank_lz   = 1'b0;
        load_valid = 1'b1;
        chk("rst_mid.ready_in", 32'(rdy_lo), 32'd1);
        tick();
        load_valid = 1'b0;
        repeat (RST_AT - 1) tick();
        reset_n = 1'b0;
        #1;
        check_out("rst_mid.asserted", 28'h0, 1'b0, 14'h0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check_out("rst_mid.released", 28'h0, 1'b0, 14'h0, 1'b0);
        repeat (25) tick();
        check_out("rst_mid.no_partial", 28'h0, 1'b0, 14'h0, 1'b0);

        do_load("after_rst", 16'h0005, 1'b0, 1'b0, 2);
        check_out("after_rst", {7'h3F, 7'h3F, 7'h3F, 7'h6D}, 1'b0, {7'h3F, 7'h6D}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Parametrised multi-digit seven-segment display controller for the platform's numeric display output. It takes a value from the platform's numeric PIO export through a valid/ready load handshake. It optionally converts the value from binary to decimal with a sequential double-dabble engine, applies leading-zero blanking and overflow indication, and drives one registered 7-segment field per digit.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits driven (1..8)
- DATA_W, 16, width of load_data (1..32)
- ACTIVE_LOW_SEG, 1, 1 = segment lit when bit is 0 (board default), 0 = lit when 1

Ports:
- clk_clk  in  1  system clock; single clock domain
- reset_reset_n  in  1  asynchronous, active-low reset
- load_valid  in  1  load request
- load_ready  out  1  controller can accept a load
- load_data  in  DATA_W  unsigned value to display
- load_mode  in  1  0 = hex, 1 = decimal; sampled with load_data
- blank_lz  in  1  1 = blank leading zeros; sampled with load_data
- segments  out  7*NUM_DIGITS  digit i on bits [7i+6:7i], bit0 = a … bit6 = g; digit 0 = least significant
- overflow  out  1  value does not fit in NUM_DIGITS digits

## Operation
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE: load_ready=1. On load_valid && load_ready, capture load_data, load_mode and blank_lz, then leave IDLE.
  - Hex mode goes to UPDATE.
  - Decimal mode clears the BCD register (4*NUM_DIGITS bits) and goes to CONVERT.
- CONVERT: one double-dabble iteration per cycle, MSB first, DATA_W iterations total.
  - Each iteration first adds 3 to every BCD nibble ≥5, then shifts left by one, bringing in the next data bit.
  - Any 1 shifted out of the BCD MSB sets the sticky overflow_pending flag.
  - After DATA_W iterations, go to UPDATE.
- Hex digits: digit i = data[4i+3:4i], with zero-extension past DATA_W. overflow_pending = |data bits at or above 4*NUM_DIGITS|.
- UPDATE: register segments and overflow for all digits in one cycle, then return to IDLE.
  - If overflow_pending: every digit shows a dash (g only) and overflow=1.
  - Otherwise: standard glyphs 0-9, A, b, C, d, E, F. Active-high codes: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - If blank_lz: every digit above the most significant nonzero digit is blank (all segments off). Digit 0 is never blanked.
- ACTIVE_LOW_SEG=1 inverts all segment bits at the output register.
- load_valid while load_ready=0 is ignored. There is no buffering, and the requester must hold load_valid.
- segments and overflow hold their last value until the next UPDATE.

## Timing
- Reset values:
  - segments all off: 7'h7F per digit if ACTIVE_LOW_SEG, else 0.
  - overflow=0.
  - load_ready=1.
  - FSM in IDLE.
- The handshake is accepted in cycle T.
- Hex mode: load_ready=0 in T+1; segments and overflow valid in T+2; load_ready=1 in T+2.
- Decimal mode:
  - CONVERT occupies T+1 … T+DATA_W.
  - UPDATE at T+DATA_W+1.
  - Outputs valid and load_ready=1 at T+DATA_W+2.
- Back-to-back loads: a new handshake is allowed in the same cycle load_ready returns high.
- Reset asserted mid-CONVERT aborts the conversion immediately. Outputs go to their reset values, and no partial result is ever displayed.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- SEG7_DECIMAL_EN defined: decimal mode and the double-dabble engine are compiled in, and the CONVERT state exists.
- SEG7_DECIMAL_EN undefined:
  - load_mode is ignored and all loads are treated as hex.
  - The converter and CONVERT state are removed.
  - Load-to-output latency is always 2 cycles.

## Test plan
- Hex, defaults, ACTIVE_LOW_SEG=0: load 0x1A3F, blank_lz=0 -> at T+2, segments digits3..0 = 06,77,4F,71; overflow=0; load_ready=1.
- Decimal, defaults, ACTIVE_LOW_SEG=0: load 1234 -> load_ready low for T+1..T+17; at T+18, digits3..0 = 06,5B,4F,66.
- Decimal overflow, defaults: load 10000 -> at T+18, every digit = 7'h3F (active-low dash); overflow=1. Then load 9999 -> digits = 6F (active-high view) and overflow=0.
- Leading-zero blanking, hex: load 0x0005 with blank_lz=1 -> digits3..1 off, digit0 = 6D. Load 0x0000 -> digit0 = 3F, others off.
- Busy handshake: hold load_valid with 0x0001 during CONVERT of 4321 -> 4321 is displayed first. The held load is accepted at the cycle load_ready rises and 1 is displayed 18 cycles later.
- Reset mid-conversion: assert reset_reset_n=0 at T+8 of a decimal load -> segments = 7'h7F per digit, overflow=0, load_ready=1 after release. Nothing is displayed until the next load completes.
